// File: rtl/tdoa_peak_search.sv
// Streaming per-pair arg-max over cross-correlation lags; emits signed TDOA and peak per mic pair.
// Optional low-confidence flag against THRESH is built only when PEAK_THRESH_EN is defined.
module tdoa_peak_search #(
   parameter int CORR_W = 32,
   parameter int LAGS   = 128,
   parameter int NPAIRS = 15,
   parameter int CENTER = 64,
   parameter int IDX_W  = $clog2(LAGS),
   parameter int PAIR_W = $clog2(NPAIRS),
   parameter int THRESH = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CORR_W-1:0] in_corr,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PAIR_W-1:0] out_pair,
   output logic [IDX_W:0]    out_tdoa,
   output logic [CORR_W-1:0] out_peak,
   output logic              out_frame_last,
   output logic              out_len_err,
   output logic              out_low_conf
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready;
   // valid never depends on ready, and an offered result stays stable until taken.

   localparam logic [0:0] SCAN = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;

   localparam logic [IDX_W-1:0]  LAST_LAG  = IDX_W'(LAGS - 1);
   localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NPAIRS - 1);
   localparam logic [IDX_W:0]    CENTER_V  = (IDX_W + 1)'(CENTER);

   logic [0:0]        state;
   logic              alive;
   logic [IDX_W-1:0]  lag_cnt;
   logic [PAIR_W-1:0] pair_cnt;
   logic [CORR_W-1:0] best_val;
   logic [IDX_W-1:0]  best_idx;
   logic [CORR_W-1:0] cand_val;
   logic [IDX_W-1:0]  cand_idx;
   logic              accept;
   logic              last_lag;
   logic              end_pair;
   logic              low_conf_d;

   // alive keeps in_ready low while reset is held even though state is SCAN
   assign in_ready = alive && (state == SCAN);
   assign accept   = in_valid && in_ready;
   assign last_lag = (lag_cnt == LAST_LAG);
   assign end_pair = accept && (in_last || last_lag);

   always_comb begin
      cand_val = best_val;
      cand_idx = best_idx;
      if ((lag_cnt == '0) || ($signed(in_corr) > $signed(best_val))) begin
         cand_val = in_corr;
         cand_idx = lag_cnt;
      end
   end

`ifdef PEAK_THRESH_EN
   localparam logic [CORR_W-1:0] THRESH_V = CORR_W'(THRESH);
   assign low_conf_d = ($signed(cand_val) < $signed(THRESH_V));
`else
   logic unused_thresh;
   assign unused_thresh = &{1'b0, 32'(THRESH)};
   assign low_conf_d    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= SCAN;
         alive          <= 1'b0;
         lag_cnt        <= '0;
         pair_cnt       <= '0;
         best_val       <= '0;
         best_idx       <= '0;
         out_valid      <= 1'b0;
         out_pair       <= '0;
         out_tdoa       <= '0;
         out_peak       <= '0;
         out_frame_last <= 1'b0;
         out_len_err    <= 1'b0;
         out_low_conf   <= 1'b0;
      end else begin
         alive <= 1'b1;
         case (state)
            SCAN: begin
               if (accept) begin
                  best_val <= cand_val;
                  best_idx <= cand_idx;
                  if (end_pair) begin
                     lag_cnt        <= '0;
                     state          <= EMIT;
                     out_valid      <= 1'b1;
                     out_pair       <= pair_cnt;
                     out_tdoa       <= {1'b0, cand_idx} - CENTER_V;
                     out_peak       <= cand_val;
                     out_frame_last <= (pair_cnt == LAST_PAIR);
                     out_len_err    <= (in_last != last_lag);
                     out_low_conf   <= low_conf_d;
                  end else begin
                     lag_cnt <= lag_cnt + 1'b1;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= SCAN;
                  pair_cnt  <= (pair_cnt == LAST_PAIR) ? '0 : pair_cnt + 1'b1;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_tdoa_peak_search.sv
// Directed bench for tdoa_peak_search: arg-max, ties, frame stalls, length errors, resets, threshold flag.
module tb_tdoa_peak_search;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_corr = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_pair;
   logic [7:0]  out_tdoa;
   logic [31:0] out_peak;
   logic        out_frame_last;
   logic        out_len_err;
   logic        out_low_conf;

   int n_checks = 0;
   int n_fail = 0;
   int exp_pair = 0;
   logic [31:0] samp [128];

   tdoa_peak_search #(.THRESH(1000)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_corr(in_corr), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_pair(out_pair), .out_tdoa(out_tdoa), .out_peak(out_peak),
      .out_frame_last(out_frame_last), .out_len_err(out_len_err), .out_low_conf(out_low_conf)
   );

   always #5 clk = ~clk;

   task automatic fill(input int v);
      for (int i = 0; i < 128; i++) samp[i] = 32'(v);
   endtask

   // Drives samp[start .. start+n-1] back to back; inputs change on negedge only.
   task automatic send_range(input int start, input int n, input bit last);
      for (int k = 0; k < n; k++) begin
         int guard = 0;
         in_valid = 1'b1;
         in_corr  = samp[start + k];
         in_last  = last && (k == n - 1);
         while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 500) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout in_ready stuck low at lag %0d", start + k);
            in_valid = 1'b0; in_last = 1'b0;
            return;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_pair = (exp_pair + 1) % 15;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_pair = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
      n_checks++; if (out_tdoa !== 8'd0) begin n_fail++; $display("FAIL rst_tdoa got %0d want 0", out_tdoa); end
      n_checks++; if (out_peak !== 32'd0) begin n_fail++; $display("FAIL rst_peak got %0d want 0", out_peak); end
      n_checks++; if ({out_pair, out_frame_last, out_len_err, out_low_conf} !== 7'd0) begin
         n_fail++; $display("FAIL rst_misc got %b want 0", {out_pair, out_frame_last, out_len_err, out_low_conf}); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b want 1", in_ready); end
      exp_pair = 0;
   endtask

   task automatic test_ramp();
      for (int i = 0; i < 128; i++) samp[i] = 32'(i);
      samp[70] = 32'd500;
      send_range(0, 127, 1'b0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_early_valid got %b want 0", out_valid); end
      send_range(127, 1, 1'b1);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ramp_latency got %b want 1", out_valid); end
      n_checks++; if (out_tdoa !== 8'(6)) begin n_fail++; $display("FAIL ramp_tdoa got %0d want 6", $signed(out_tdoa)); end
      n_checks++; if (out_peak !== 32'd500) begin n_fail++; $display("FAIL ramp_peak got %0d want 500", $signed(out_peak)); end
      n_checks++; if (out_pair !== 4'd0) begin n_fail++; $display("FAIL ramp_pair got %0d want 0", out_pair); end
      n_checks++; if (out_len_err !== 1'b0) begin n_fail++; $display("FAIL ramp_len_err got %b want 0", out_len_err); end
      ack();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_valid_drop got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ramp_ready_back got %b want 1", in_ready); end
   endtask

   task automatic test_tie();
      fill(-20);
      samp[10] = 32'd9; samp[90] = 32'd9;
      send_range(0, 128, 1'b1);
      n_checks++; if (out_tdoa !== 8'(-54)) begin n_fail++; $display("FAIL tie_tdoa got %0d want -54", $signed(out_tdoa)); end
      n_checks++; if (out_peak !== 32'd9) begin n_fail++; $display("FAIL tie_peak got %0d want 9", $signed(out_peak)); end
      n_checks++; if (out_pair !== 4'(exp_pair)) begin n_fail++; $display("FAIL tie_pair got %0d want %0d", out_pair, exp_pair); end
      ack();
      fill(-5);
      send_range(0, 128, 1'b1);
      n_checks++; if (out_tdoa !== 8'(-64)) begin n_fail++; $display("FAIL flat_tdoa got %0d want -64", $signed(out_tdoa)); end
      n_checks++; if (out_peak !== 32'(-5)) begin n_fail++; $display("FAIL flat_peak got %0d want -5", $signed(out_peak)); end
      ack();
   endtask

   task automatic test_frame();
      do_reset();
      for (int p = 0; p < 16; p++) begin
         fill(-1000);
         samp[64 + (p % 15)] = 32'(2000 + p);
         send_range(0, 128, 1'b1);
         for (int s = 0; s < 3; s++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL frame_valid p%0d got %b want 1", p, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL frame_in_ready p%0d got %b want 0", p, in_ready); end
            n_checks++; if (out_tdoa !== 8'(p % 15)) begin n_fail++; $display("FAIL frame_tdoa p%0d got %0d want %0d", p, $signed(out_tdoa), p % 15); end
            n_checks++; if (out_peak !== 32'(2000 + p)) begin n_fail++; $display("FAIL frame_peak p%0d got %0d want %0d", p, $signed(out_peak), 2000 + p); end
            n_checks++; if (out_pair !== 4'(exp_pair)) begin n_fail++; $display("FAIL frame_pair p%0d got %0d want %0d", p, out_pair, exp_pair); end
            n_checks++; if (out_frame_last !== (p == 14)) begin n_fail++; $display("FAIL frame_last p%0d got %b want %b", p, out_frame_last, p == 14); end
            @(negedge clk);
         end
         ack();
      end
   endtask

   task automatic test_len_err();
      fill(-1);
      samp[20] = 32'd300;
      send_range(0, 41, 1'b1);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL short_valid got %b want 1", out_valid); end
      n_checks++; if (out_len_err !== 1'b1) begin n_fail++; $display("FAIL short_len_err got %b want 1", out_len_err); end
      n_checks++; if (out_tdoa !== 8'(-44)) begin n_fail++; $display("FAIL short_tdoa got %0d want -44", $signed(out_tdoa)); end
      ack();
      fill(-1);
      samp[100] = 32'd77;
      send_range(0, 128, 1'b0);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nolast_valid got %b want 1", out_valid); end
      n_checks++; if (out_len_err !== 1'b1) begin n_fail++; $display("FAIL nolast_len_err got %b want 1", out_len_err); end
      n_checks++; if (out_tdoa !== 8'(36)) begin n_fail++; $display("FAIL nolast_tdoa got %0d want 36", $signed(out_tdoa)); end
      n_checks++; if (out_pair !== 4'(exp_pair)) begin n_fail++; $display("FAIL nolast_pair got %0d want %0d", out_pair, exp_pair); end
      ack();
   endtask

   task automatic test_reset_mid();
      do_reset();
      fill(-1);
      samp[64] = 32'd10;
      for (int p = 0; p < 3; p++) begin
         send_range(0, 128, 1'b1);
         ack();
      end
      fill(-1);
      samp[10] = 32'd5000;
      send_range(0, 51, 1'b0);
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midpair_rst_valid got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midpair_rst_ready got %b want 0", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_pair = 0;
      fill(-1);
      samp[5] = 32'd42;
      send_range(0, 128, 1'b1);
      n_checks++; if (out_pair !== 4'd0) begin n_fail++; $display("FAIL postrst_pair got %0d want 0", out_pair); end
      n_checks++; if (out_tdoa !== 8'(-59)) begin n_fail++; $display("FAIL postrst_tdoa got %0d want -59", $signed(out_tdoa)); end
      n_checks++; if (out_peak !== 32'd42) begin n_fail++; $display("FAIL postrst_peak got %0d want 42", $signed(out_peak)); end
      n_checks++; if (out_len_err !== 1'b0) begin n_fail++; $display("FAIL postrst_len_err got %b want 0", out_len_err); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL emit_rst_valid got %b want 0", out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_pair = 0;
   endtask

   task automatic test_thresh();
      logic exp_lo;
      fill(-2000);
      samp[64] = 32'd999;
      send_range(0, 128, 1'b1);
`ifdef PEAK_THRESH_EN
      exp_lo = 1'b1;
`else
      exp_lo = 1'b0;
`endif
      n_checks++; if (out_low_conf !== exp_lo) begin n_fail++; $display("FAIL thresh_999 got %b want %b", out_low_conf, exp_lo); end
      n_checks++; if (out_peak !== 32'd999) begin n_fail++; $display("FAIL thresh_999_peak got %0d want 999", $signed(out_peak)); end
      ack();
      samp[64] = 32'd1000;
      send_range(0, 128, 1'b1);
      n_checks++; if (out_low_conf !== 1'b0) begin n_fail++; $display("FAIL thresh_1000 got %b want 0", out_low_conf); end
      n_checks++; if (out_pair !== 4'(exp_pair)) begin n_fail++; $display("FAIL thresh_pair got %0d want %0d", out_pair, exp_pair); end
      ack();
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_tie();
      test_frame();
      test_len_err();
      test_reset_mid();
      test_thresh();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation did not complete");
      $fatal(1);
   end

endmodule
